// File: rtl/fifo_arb_pkg.sv
// Shared types, defaults and the round-robin scan used by the FIFO put arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int DEFAULT_DATA_W    = 32;
  localparam int DEFAULT_MAX_BURST = 4;
  localparam int MAX_REQ           = 8;

  // Scan last+1, last+2, ... wrapping modulo n; last itself is tried last.
  // Returns the first requesting index, or -1 when nobody requests.
  function automatic int rr_select(input logic [MAX_REQ-1:0] req,
                                   input logic [2:0]         last,
                                   input int                 n);
    int result;
    int cand;
    logic [2:0] idx;
    result = -1;
    for (int k = 1; k <= MAX_REQ; k++) begin
      cand = (int'(last) + k) % n;
      idx  = 3'(cand);
      if (k <= n && result < 0 && req[idx]) begin
        result = cand;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_put_arbiter_rr_pick.sv
// Combinational round-robin pick: winner index and found flag for a req vector.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [IDX_W-1:0]   winner,
  output logic               found
);

  logic [MAX_REQ-1:0] req_ext;
  int                 sel;

  always_comb begin
    req_ext                = '0;
    req_ext[NUM_REQ-1:0]   = req;
    sel                    = rr_select(req_ext, 3'(last), NUM_REQ);
    found                  = (sel >= 0);
    winner                 = IDX_W'(sel);
  end

endmodule

// File: rtl/fifo_put_arbiter.sv
// Round-robin arbiter sharing one FIFO put port among NUM_REQ producers with bounded bursts.
// Optional FIFO_PUT_ARB_STATS_EN adds a saturating stall_cnt of full-blocked GRANT cycles.
module fifo_put_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        grant,
  input  logic                      fifo_full,
  output logic                      fifo_put,
  output logic [DATA_W-1:0]         fifo_data,
  output logic                      busy
`ifdef FIFO_PUT_ARB_STATS_EN
  ,
  output logic [15:0]               stall_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t       state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] last_owner;
  logic [IDX_W-1:0] pick_last;
  logic [IDX_W-1:0] win_idx;
  logic             win_found;
  logic [3:0]       burst_cnt;
  logic             req_owner;
  logic             last_word;
  logic             release_now;

  // On release the just-finished owner becomes the new lowest priority.
  assign pick_last = (state == GRANT) ? owner : last_owner;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req    (req),
    .last   (pick_last),
    .winner (win_idx),
    .found  (win_found)
  );

  assign req_owner   = req[owner];
  assign fifo_put    = (state == GRANT) & req_owner & ~fifo_full & ~reset;
  assign last_word   = (burst_cnt == 4'(MAX_BURST - 1));
  assign release_now = (state == GRANT) & (~req_owner | (fifo_put & last_word));
  assign fifo_data   = wdata[int'(owner)*DATA_W +: DATA_W];
  assign busy        = (state == GRANT);

  always_comb begin
    ack = '0;
    if (fifo_put) begin
      ack[owner] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      owner      <= '0;
      last_owner <= IDX_W'(NUM_REQ - 1);
      burst_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            state     <= GRANT;
            owner     <= win_idx;
            grant     <= NUM_REQ'(1) << win_idx;
            burst_cnt <= '0;
          end
        end
        GRANT: begin
          if (release_now) begin
            last_owner <= owner;
            burst_cnt  <= '0;
            if (win_found) begin
              owner <= win_idx;
              grant <= NUM_REQ'(1) << win_idx;
            end else begin
              state <= IDLE;
              grant <= '0;
            end
          end else if (fifo_put) begin
            burst_cnt <= burst_cnt + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

`ifdef FIFO_PUT_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if ((state == GRANT) && req_owner && fifo_full && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
